// File: rtl/demod64_atan_if.sv
// Stream beat bundle (valid/ready/data/last/strobe) shared by the discriminator input and output.
// The master drives the beat and the slave returns ready.
interface demod64_atan_if #(
  parameter int DW = 64
) ();
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;

  modport master (output tvalid, tlast, tdata, tstrb, input tready);
  modport slave  (input tvalid, tlast, tdata, tstrb, output tready);
endinterface

// File: rtl/demod64_atan.sv
// Vectoring CORDIC: {imag,real} -> {phase, uncompensated magnitude}, latency N_STAGES+2, 1 beat/cycle.
// A single global enable stalls every stage while the output beat waits; input ready is that enable.
module demod64_atan #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int N_STAGES               = 16
) (
  input  logic           s00_axis_aclk,
  input  logic           s00_axis_areset,
  demod64_atan_if.slave  s00_axis,
  demod64_atan_if.master m00_axis
);

  localparam logic [15:0] ATAN_LUT [16] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297, 16'd651, 16'd326, 16'd163, 16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,    16'd3,   16'd1,   16'd1,   16'd0
  };

  logic               en;
  logic signed [33:0] re_w, im_w, pre_x, pre_y;
  logic [15:0]        pre_z;
  logic               pre_zero;

  logic signed [33:0] x_q [N_STAGES+1];
  logic signed [33:0] y_q [N_STAGES+1];
  logic [15:0]        z_q [N_STAGES+1];
  logic signed [33:0] x_d [N_STAGES];
  logic signed [33:0] y_d [N_STAGES];
  logic [15:0]        z_d [N_STAGES];
  logic [N_STAGES:0]  vld_q, last_q, zero_q;

  logic               m_vld_q, m_last_q;
  logic [31:0]        m_dat_q;
  logic [3:0]         m_strb_q;
  logic               unused_bits;

  assign en              = ~m_vld_q | m00_axis.tready;
  assign s00_axis.tready = en;

  // 34-bit datapath makes negating -2^31 exact and leaves headroom for the CORDIC gain.
  assign re_w     = {{2{s00_axis.tdata[31]}}, s00_axis.tdata[31:0]};
  assign im_w     = {{2{s00_axis.tdata[63]}}, s00_axis.tdata[63:32]};
  assign pre_x    = re_w[33] ? -re_w : re_w;
  assign pre_y    = re_w[33] ? -im_w : im_w;
  assign pre_z    = re_w[33] ? 16'h8000 : 16'h0000;
  assign pre_zero = (s00_axis.tdata == 64'd0);

  for (genvar i = 0; i < N_STAGES; i++) begin : g_rot
    logic d;
    assign d      = ~y_q[i][33];
    assign x_d[i] = d ? x_q[i] + (y_q[i] >>> i) : x_q[i] - (y_q[i] >>> i);
    assign y_d[i] = d ? y_q[i] - (x_q[i] >>> i) : y_q[i] + (x_q[i] >>> i);
    assign z_d[i] = d ? z_q[i] + ATAN_LUT[i]    : z_q[i] - ATAN_LUT[i];
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      vld_q    <= '0;
      last_q   <= '0;
      zero_q   <= '0;
      for (int i = 0; i <= N_STAGES; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
      end
      m_vld_q  <= 1'b0;
      m_last_q <= 1'b0;
      m_dat_q  <= '0;
      m_strb_q <= '0;
    end else if (en) begin
      vld_q  <= {vld_q[N_STAGES-1:0],  s00_axis.tvalid};
      last_q <= {last_q[N_STAGES-1:0], s00_axis.tlast};
      zero_q <= {zero_q[N_STAGES-1:0], pre_zero};
      x_q[0] <= pre_x;
      y_q[0] <= pre_y;
      z_q[0] <= pre_z;
      for (int i = 0; i < N_STAGES; i++) begin
        x_q[i+1] <= x_d[i];
        y_q[i+1] <= y_d[i];
        z_q[i+1] <= z_d[i];
      end
      m_vld_q  <= vld_q[N_STAGES];
      m_last_q <= last_q[N_STAGES];
      m_strb_q <= {4{vld_q[N_STAGES]}};
      // A zero vector never steers the rotations, so its accumulated angle is meaningless.
      m_dat_q  <= {zero_q[N_STAGES] ? 16'h0000 : z_q[N_STAGES], x_q[N_STAGES][32:17]};
    end
  end

  assign m00_axis.tvalid = m_vld_q;
  assign m00_axis.tlast  = m_last_q;
  assign m00_axis.tdata  = m_dat_q;
  assign m00_axis.tstrb  = m_strb_q;

  assign unused_bits = ^{s00_axis.tstrb, x_q[N_STAGES][33], x_q[N_STAGES][16:0], y_q[N_STAGES]};

endmodule
